l1_repl_ctrl: RTL and testbench

Parametrised L1 replacement controller: the successor to the fixed-geometry pseudo-LRU tracker, with configurable way and set counts. It sits beside the tag array in the two-stage L1 lookup pipeline and reports hit, hit way and allocation/eviction way. It keeps one MRU-bit vector per set in a dual-port SRAM. Over the previous generation it adds invalid-way-first allocation, multi-hit detection, a runtime flush that re-runs the clean sweep, and an optional per-way disable mask.

---
 rtl/l1_repl_ctrl.sv | 159 +++++++++++++++
 tb/tb_l1_repl_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/l1_repl_ctrl.sv
// L1 replacement controller: per-set MRU-bit tracking with invalid-first allocation.
// Optional per-way disable mask enabled by defining L1_REPL_WAYMASK_EN.
module l1_repl_ctrl #(
  parameter int unsigned WAY_NUM = 4,
  parameter int unsigned SET_NUM = 64,
  parameter int unsigned IDX_W   = $clog2(SET_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic [IDX_W-1:0]   idx,
  input  logic               flush,
  output logic               ready,
  input  logic [WAY_NUM-1:0] ld_val_vect,
  input  logic [WAY_NUM-1:0] tag_cmp_vect,
`ifdef L1_REPL_WAYMASK_EN
  input  logic [WAY_NUM-1:0] way_dis,
`endif
  output logic               hit,
  output logic               multi_hit,
  output logic               evict_val,
  output logic [WAY_NUM-1:0] way_vect
);

`ifndef L1_REPL_WAYMASK_EN
  logic [WAY_NUM-1:0] way_dis;
  assign way_dis = '0;
`endif

  typedef enum logic [0:0] {StInit, StReady} state_e;

  function automatic logic [WAY_NUM-1:0] lowest_bit(input logic [WAY_NUM-1:0] v);
    logic [WAY_NUM-1:0] r;
    r = '0;
    for (int i = WAY_NUM - 1; i >= 0; i--) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [WAY_NUM-1:0] highest_bit(input logic [WAY_NUM-1:0] v);
    logic [WAY_NUM-1:0] r;
    r = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               req_r, bypass_q;
  logic [IDX_W-1:0]   idx_r;
  logic [WAY_NUM-1:0] next_q, rd_q;
  logic [WAY_NUM-1:0] mem [SET_NUM];

  logic               accept, any_en, upd_we, mem_we;
  logic [WAY_NUM-1:0] en, used, hit_vect, inv_vect, cand, upd, next_mru, mem_wdata;
  logic [IDX_W-1:0]   mem_waddr;

  assign ready  = (state_q == StReady);
  assign accept = req & ready & ~flush;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StInit: begin
        sweep_d = sweep_q + IDX_W'(1);
        if (sweep_q == IDX_W'(SET_NUM - 1)) begin
          state_d = StReady;
          sweep_d = '0;
        end
      end
      StReady: begin
        if (flush) begin
          state_d = StInit;
          sweep_d = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // The SRAM read returns pre-write data, so a same-set follow-up uses the registered next value.
  assign used     = bypass_q ? next_q : rd_q;
  assign en       = ~way_dis;
  assign any_en   = |en;
  assign hit_vect = ld_val_vect & tag_cmp_vect & en;
  assign inv_vect = ~ld_val_vect & en;
  assign cand     = en & ~used;

  always_comb begin
    hit       = 1'b0;
    multi_hit = 1'b0;
    evict_val = 1'b0;
    way_vect  = '0;
    if (req_r && any_en) begin
      if (|hit_vect) begin
        hit       = 1'b1;
        multi_hit = ($countones(hit_vect) > 1);
        way_vect  = lowest_bit(hit_vect);
      end else if (|inv_vect) begin
        way_vect  = lowest_bit(inv_vect);
      end else begin
        evict_val = 1'b1;
        way_vect  = (|cand) ? highest_bit(cand) : highest_bit(en);
      end
    end
  end

  // Once every enabled way is marked used, restart from just the way touched now.
  assign upd      = used | way_vect;
  assign next_mru = (&(upd | way_dis)) ? way_vect : upd;
  assign upd_we   = req_r & any_en & ~flush & (state_q == StReady);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx_r;
    mem_wdata = next_mru;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_q;
      mem_wdata = '0;
    end else if (upd_we) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (accept) rd_q <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StInit;
      sweep_q  <= '0;
      req_r    <= 1'b0;
      idx_r    <= '0;
      bypass_q <= 1'b0;
      next_q   <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      req_r    <= accept;
      idx_r    <= idx;
      bypass_q <= accept & req_r & (idx == idx_r);
      next_q   <= upd_we ? next_mru : used;
    end
  end

endmodule

// File: tb/tb_l1_repl_ctrl.sv
// Scoreboard bench for l1_repl_ctrl: a per-cycle reference model pushes expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_l1_repl_ctrl;
  localparam int unsigned WAY_NUM = 4;
  localparam int unsigned SET_NUM = 64;
  localparam int unsigned IDX_W   = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               req = 1'b0;
  logic               flush = 1'b0;
  logic [IDX_W-1:0]   idx = '0;
  logic [WAY_NUM-1:0] ld_val_vect = '0;
  logic [WAY_NUM-1:0] tag_cmp_vect = '0;
  logic [WAY_NUM-1:0] way_dis = '0;
  logic               ready, hit, multi_hit, evict_val;
  logic [WAY_NUM-1:0] way_vect;

  l1_repl_ctrl #(.WAY_NUM(WAY_NUM), .SET_NUM(SET_NUM)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .idx          (idx),
    .flush        (flush),
    .ready        (ready),
    .ld_val_vect  (ld_val_vect),
    .tag_cmp_vect (tag_cmp_vect),
`ifdef L1_REPL_WAYMASK_EN
    .way_dis      (way_dis),
`endif
    .hit          (hit),
    .multi_hit    (multi_hit),
    .evict_val    (evict_val),
    .way_vect     (way_vect)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               rdy;
    logic               hit;
    logic               mh;
    logic               ev;
    logic [WAY_NUM-1:0] way;
  } resp_t;

  resp_t       exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference state: used-bit set per set, remaining sweep cycles, one pending lookup.
  logic [WAY_NUM-1:0] m_used [SET_NUM];
  int                 m_sweep;
  bit                 m_pend;
  int                 m_pidx;

  task automatic model_clear();
    for (int s = 0; s < SET_NUM; s++) m_used[s] = '0;
  endtask

  // Drive one cycle; lv/tc belong to the lookup issued on the previous cycle.
  task automatic step(input bit r, input int ix, input logic [WAY_NUM-1:0] lv,
                      input logic [WAY_NUM-1:0] tc, input bit fl, input bit rs);
    resp_t e;
    bit    accept;
    int    nh, first_hit, inv, pick;
    logic [WAY_NUM-1:0] u;
    rst = rs; req = r; idx = IDX_W'(ix); ld_val_vect = lv; tag_cmp_vect = tc; flush = fl;
    e = '0;
    e.rdy = (m_sweep == 0);
    if (m_pend && way_dis != '1) begin
      nh = 0; first_hit = -1; inv = -1;
      for (int w = 0; w < WAY_NUM; w++) begin
        if (!way_dis[w] && lv[w] && tc[w]) begin
          nh++;
          if (first_hit < 0) first_hit = w;
        end
        if (!way_dis[w] && !lv[w] && inv < 0) inv = w;
      end
      if (nh > 0) begin
        e.hit = 1'b1; e.mh = (nh > 1); e.way[first_hit] = 1'b1;
      end else if (inv >= 0) begin
        e.way[inv] = 1'b1;
      end else begin
        e.ev = 1'b1;
        pick = -1;
        for (int w = WAY_NUM - 1; w >= 0 && pick < 0; w--)
          if (!way_dis[w] && !m_used[m_pidx][w]) pick = w;
        for (int w = WAY_NUM - 1; w >= 0 && pick < 0; w--)
          if (!way_dis[w]) pick = w;
        e.way[pick] = 1'b1;
      end
      u = m_used[m_pidx] | e.way;
      if ((u | way_dis) == '1) u = e.way;
      if (!fl) m_used[m_pidx] = u;
    end
    exp_q.push_back(e);
    accept = r && (m_sweep == 0) && !fl;
    if (rs) begin
      m_sweep = SET_NUM; m_pend = 0; model_clear();
    end else begin
      if (m_sweep == 0 && fl) begin
        m_sweep = SET_NUM; model_clear();
      end else if (m_sweep > 0) begin
        m_sweep--;
      end
      m_pend = accept; m_pidx = ix;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_until_ready();
    for (int i = 0; i < 2 * SET_NUM && m_sweep != 0; i++) step(0, 0, '0, '0, 0, 0);
  endtask

  task automatic flush_and_wait();
    step(0, 0, '0, '0, 1, 0);
    idle_until_ready();
  endtask

  always @(negedge clk) begin
    resp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{rdy: ready, hit: hit, mh: multi_hit, ev: evict_val, way: way_vect};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL resp t=%0t got rdy=%b hit=%b mh=%b ev=%b way=%b exp rdy=%b hit=%b mh=%b ev=%b way=%b",
                 $time, a.rdy, a.hit, a.mh, a.ev, a.way, e.rdy, e.hit, e.mh, e.ev, e.way);
      end
    end
  end

  initial begin
    m_sweep = SET_NUM; m_pend = 0; model_clear();
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, 1);
    idle_until_ready();
    // Every set reads back cleared: all-valid misses allocate the top way.
    for (int s = 0; s < SET_NUM; s++) step(1, s, 4'hF, 4'h0, 0, 0);
    step(0, 0, 4'hF, 4'h0, 0, 0);
    flush_and_wait();
    // Saturation walk on set 5.
    for (int i = 0; i < 5; i++) step(1, 5, 4'hF, 4'h0, 0, 0);
    step(0, 0, 4'hF, 4'h0, 0, 0);
    // Invalid-first allocation, then a double hit.
    step(1, 7, '0, '0, 0, 0);
    step(1, 7, 4'b1011, 4'h0, 0, 0);
    step(0, 0, 4'hF, 4'b0011, 0, 0);
    // Hit way 0 then miss on the same set through the bypass.
    step(1, 9, '0, '0, 0, 0);
    step(1, 9, 4'hF, 4'b0001, 0, 0);
    step(0, 0, 4'hF, 4'h0, 0, 0);
    // Flush during an analyse-stage hit, and a req coinciding with flush.
    step(1, 9, '0, '0, 0, 0);
    step(1, 9, 4'hF, 4'b0001, 1, 0);
    idle_until_ready();
    step(1, 9, '0, '0, 0, 0);
    step(0, 0, 4'hF, 4'h0, 0, 0);
`ifdef L1_REPL_WAYMASK_EN
    way_dis = 4'b1000;
    for (int i = 0; i < 5; i++) step(1, 11, 4'hF, 4'h0, 0, 0);
    step(0, 0, 4'hF, 4'b1000, 0, 0);
    way_dis = 4'b1111;
    step(1, 12, '0, '0, 0, 0);
    step(0, 0, 4'hF, 4'hF, 0, 0);
    way_dis = '0;
`endif
    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      bit                 r, fl, rs;
      int                 ix;
      logic [WAY_NUM-1:0] lv, tc;
      r  = ($urandom_range(0, 9) < 7);
      ix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SET_NUM - 1))
                                       : int'($urandom_range(0, 3));
      lv = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      tc = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      fl = ($urandom_range(0, 59) == 0);
      rs = ($urandom_range(0, 799) == 0);
`ifdef L1_REPL_WAYMASK_EN
      way_dis = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
`endif
      step(r, ix, lv, tc, fl, rs);
    end
    step(0, 0, '0, '0, 0, 0);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
